mem_port_arbiter: RTL and testbench

Two-requester arbiter that shares one port of the on-chip dual-port block RAM between the CPU control/datapath and a second master (display or I/O DMA). It serializes single-word read and write transactions with a req/ack handshake, applies round-robin priority on contention, and hides the RAM's fixed read latency from both requesters. It sits between the requesters and the RAM port's address, data-in, wren and q pins.

---
 rtl/mem_port_arbiter.sv | 164 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Two-requester round-robin arbiter for one port of the dual-port block RAM.
// Serializes single-word reads and writes and hides the RAM read latency behind req/ack.
module mem_port_arbiter #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16,
    parameter int RD_LAT = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              r0_req,
    input  logic              r0_we,
    input  logic [ADDR_W-1:0] r0_addr,
    input  logic [DATA_W-1:0] r0_wdata,
    input  logic              r1_req,
    input  logic              r1_we,
    input  logic [ADDR_W-1:0] r1_addr,
    input  logic [DATA_W-1:0] r1_wdata,
    output logic              r0_ack,
    output logic              r1_ack,
    output logic [DATA_W-1:0] r0_rdata,
    output logic [DATA_W-1:0] r1_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_wren,
    input  logic [DATA_W-1:0] mem_q,
    output logic              busy,
    output logic              owner,
    output logic [1:0]        dbg_state
);

    // Handshake: a requester raises req with we/addr/wdata and holds all of them
    // stable until it samples its one-cycle ack; req is only looked at in IDLE.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        ACK   = 2'd3
    } state_t;

    localparam logic [2:0] WAIT_INIT = (RD_LAT > 1) ? 3'(RD_LAT - 2) : 3'd0;

    state_t            state;
    logic              last_owner;
    logic              lat_we;
    logic [2:0]        wait_cnt;

    logic              gnt_valid;
    logic              gnt_sel;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

    // On contention the requester that did not win last time is chosen.
    always_comb begin
        gnt_valid = r0_req | r1_req;
        gnt_sel   = 1'b0;
        if (r0_req && r1_req) begin
            gnt_sel = ~last_owner;
        end else if (r1_req) begin
            gnt_sel = 1'b1;
        end
    end

    always_comb begin
        sel_we    = gnt_sel ? r1_we    : r0_we;
        sel_addr  = gnt_sel ? r1_addr  : r0_addr;
        sel_wdata = gnt_sel ? r1_wdata : r0_wdata;
    end

    assign dbg_state = state;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            last_owner <= 1'b1;
            lat_we     <= 1'b0;
            wait_cnt   <= 3'd0;
            r0_ack     <= 1'b0;
            r1_ack     <= 1'b0;
            r0_rdata   <= '0;
            r1_rdata   <= '0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_wren   <= 1'b0;
            busy       <= 1'b0;
            owner      <= 1'b0;
        end else begin
            r0_ack <= 1'b0;
            r1_ack <= 1'b0;
            case (state)
                IDLE: begin
                    if (gnt_valid) begin
                        owner      <= gnt_sel;
                        last_owner <= gnt_sel;
                        lat_we     <= sel_we;
                        mem_addr   <= sel_addr;
                        mem_wdata  <= sel_wdata;
                        mem_wren   <= sel_we;
                        busy       <= 1'b1;
                        state      <= ISSUE;
                    end
                end
                ISSUE: begin
                    mem_wren <= 1'b0;
                    if (lat_we) begin
                        state <= ACK;
                        if (owner) r1_ack <= 1'b1;
                        else       r0_ack <= 1'b1;
                    end else if (RD_LAT > 1) begin
                        state    <= WAIT;
                        wait_cnt <= WAIT_INIT;
                    end else begin
                        // Single-cycle RAM: q is already valid at the end of ISSUE.
                        state <= ACK;
                        if (owner) begin
                            r1_ack   <= 1'b1;
                            r1_rdata <= mem_q;
                        end else begin
                            r0_ack   <= 1'b1;
                            r0_rdata <= mem_q;
                        end
                    end
                end
                WAIT: begin
                    if (wait_cnt == 3'd0) begin
                        state <= ACK;
                        if (owner) begin
                            r1_ack   <= 1'b1;
                            r1_rdata <= mem_q;
                        end else begin
                            r0_ack   <= 1'b1;
                            r0_rdata <= mem_q;
                        end
                    end else begin
                        wait_cnt <= wait_cnt - 3'd1;
                    end
                end
                ACK: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    a_rd_lat_legal: assert property (@(posedge clk) (RD_LAT >= 1) && (RD_LAT <= 7));

    a_ack_onehot: assert property (@(posedge clk) disable iff (!reset)
        !(r0_ack && r1_ack));

    a_ack_in_ack_state: assert property (@(posedge clk) disable iff (!reset)
        (r0_ack || r1_ack) |-> (state == ACK));

    a_wren_only_issue: assert property (@(posedge clk) disable iff (!reset)
        mem_wren |-> (state == ISSUE && lat_we));

    a_busy_matches_state: assert property (@(posedge clk) disable iff (!reset)
        busy == (state != IDLE));

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: RD_LAT=2 instance with a RAM model plus an RD_LAT=1 instance.
module tb_mem_port_arbiter;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_ACK   = 2'd3;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    int          errors = 0;
    int          checks = 0;

    // RD_LAT=2 instance
    logic        r0_req = 0, r0_we = 0, r1_req = 0, r1_we = 0;
    logic [15:0] r0_addr = 0, r0_wdata = 0, r1_addr = 0, r1_wdata = 0;
    logic        r0_ack, r1_ack, mem_wren, busy, owner;
    logic [15:0] r0_rdata, r1_rdata, mem_addr, mem_wdata, mem_q;
    logic [1:0]  dbg_state;
    logic [15:0] mem_a [0:65535];

    // RD_LAT=1 instance
    logic        b_r0_req = 0, b_r0_we = 0, b_r1_req = 0, b_r1_we = 0;
    logic [15:0] b_r0_addr = 0, b_r0_wdata = 0, b_r1_addr = 0, b_r1_wdata = 0;
    logic        b_r0_ack, b_r1_ack, b_mem_wren, b_busy, b_owner;
    logic [15:0] b_r0_rdata, b_r1_rdata, b_mem_addr, b_mem_wdata, b_mem_q;
    logic [1:0]  b_dbg_state;
    logic [15:0] mem_b [0:65535];

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(16), .DATA_W(16), .RD_LAT(2)) dut (
        .clk(clk), .reset(reset),
        .r0_req(r0_req), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
        .r1_req(r1_req), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
        .r0_ack(r0_ack), .r1_ack(r1_ack), .r0_rdata(r0_rdata), .r1_rdata(r1_rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wren(mem_wren), .mem_q(mem_q),
        .busy(busy), .owner(owner), .dbg_state(dbg_state)
    );

    mem_port_arbiter #(.ADDR_W(16), .DATA_W(16), .RD_LAT(1)) dut_b (
        .clk(clk), .reset(reset),
        .r0_req(b_r0_req), .r0_we(b_r0_we), .r0_addr(b_r0_addr), .r0_wdata(b_r0_wdata),
        .r1_req(b_r1_req), .r1_we(b_r1_we), .r1_addr(b_r1_addr), .r1_wdata(b_r1_wdata),
        .r0_ack(b_r0_ack), .r1_ack(b_r1_ack), .r0_rdata(b_r0_rdata), .r1_rdata(b_r1_rdata),
        .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata), .mem_wren(b_mem_wren), .mem_q(b_mem_q),
        .busy(b_busy), .owner(b_owner), .dbg_state(b_dbg_state)
    );

    // RAM with q valid RD_LAT edges after the address appears: one register stage for RD_LAT=2.
    initial begin
        mem_a[16'h0010] = 16'hBEEF;
        mem_b[16'h0020] = 16'hCAFE;
    end

    always @(posedge clk) begin
        if (mem_wren) mem_a[mem_addr] <= mem_wdata;
        mem_q <= mem_a[mem_addr];
    end

    always @(posedge clk) begin
        if (b_mem_wren) mem_b[b_mem_addr] <= b_mem_wdata;
    end
    assign b_mem_q = mem_b[b_mem_addr];

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        tick(); tick();
        checks++;
        if ({r0_ack, r1_ack, busy, owner, mem_wren} !== 5'b0) begin
            errors++; $display("FAIL reset_flags: got %b expected 00000", {r0_ack, r1_ack, busy, owner, mem_wren});
        end
        checks++;
        if ({mem_addr, mem_wdata, r0_rdata, r1_rdata} !== 64'h0) begin
            errors++; $display("FAIL reset_data: got %h expected 0", {mem_addr, mem_wdata, r0_rdata, r1_rdata});
        end
        checks++;
        if ({dbg_state, b_dbg_state, b_busy, b_r0_ack} !== 6'b0) begin
            errors++; $display("FAIL reset_state: got %b expected 000000", {dbg_state, b_dbg_state, b_busy, b_r0_ack});
        end
        reset = 1'b1;
    endtask

    task automatic test_read_r0();
        r0_req = 1; r0_we = 0; r0_addr = 16'h0010;
        tick();
        checks++;
        if ({dbg_state, busy, owner, mem_wren, r0_ack} !== {S_ISSUE, 4'b1000} || mem_addr !== 16'h0010) begin
            errors++; $display("FAIL read_issue: got st=%0d busy=%b own=%b wren=%b ack=%b addr=%h expected st=1 busy=1 own=0 wren=0 ack=0 addr=0010",
                               dbg_state, busy, owner, mem_wren, r0_ack, mem_addr);
        end
        tick();
        checks++;
        if ({dbg_state, r0_ack, mem_wren} !== {S_WAIT, 2'b00} || mem_addr !== 16'h0010) begin
            errors++; $display("FAIL read_wait: got st=%0d ack=%b wren=%b addr=%h expected st=2 ack=0 wren=0 addr=0010", dbg_state, r0_ack, mem_wren, mem_addr);
        end
        tick();
        checks++;
        if ({r0_ack, r1_ack} !== 2'b10 || r0_rdata !== 16'hBEEF) begin
            errors++; $display("FAIL read_ack: got r0_ack=%b r1_ack=%b rdata=%h expected 1 0 beef", r0_ack, r1_ack, r0_rdata);
        end
        r0_req = 0;
        tick();
        checks++;
        if ({r0_ack, busy, dbg_state} !== {2'b00, S_IDLE} || r0_rdata !== 16'hBEEF) begin
            errors++; $display("FAIL read_after: got ack=%b busy=%b st=%0d rdata=%h expected 0 0 0 beef", r0_ack, busy, dbg_state, r0_rdata);
        end
    endtask

    task automatic test_write_r1();
        r1_req = 1; r1_we = 1; r1_addr = 16'h00FF; r1_wdata = 16'h1234;
        tick();
        checks++;
        if ({mem_wren, owner, r1_ack} !== 3'b110 || mem_addr !== 16'h00FF || mem_wdata !== 16'h1234) begin
            errors++; $display("FAIL write_issue: got wren=%b own=%b ack=%b addr=%h wdata=%h expected 1 1 0 00ff 1234",
                               mem_wren, owner, r1_ack, mem_addr, mem_wdata);
        end
        tick();
        checks++;
        if ({mem_wren, r1_ack, r0_ack, dbg_state} !== {3'b010, S_ACK}) begin
            errors++; $display("FAIL write_ack: got wren=%b r1_ack=%b r0_ack=%b st=%0d expected 0 1 0 3", mem_wren, r1_ack, r0_ack, dbg_state);
        end
        r1_req = 0; r1_we = 0;
        tick();
        checks++;
        if ({r1_ack, busy, mem_wren} !== 3'b000 || r1_rdata !== 16'h0000) begin
            errors++; $display("FAIL write_after: got ack=%b busy=%b wren=%b r1_rdata=%h expected 0 0 0 0000", r1_ack, busy, mem_wren, r1_rdata);
        end
        // read back through r0
        r0_req = 1; r0_we = 0; r0_addr = 16'h00FF;
        tick(); tick(); tick();
        checks++;
        if (r0_ack !== 1'b1 || r0_rdata !== 16'h1234) begin
            errors++; $display("FAIL write_readback: got ack=%b rdata=%h expected 1 1234", r0_ack, r0_rdata);
        end
        r0_req = 0;
        tick();
    endtask

    task automatic test_contention();
        reset = 0;
        tick();
        reset = 1;
        r0_req = 1; r0_we = 0; r0_addr = 16'h0010;
        r1_req = 1; r1_we = 0; r1_addr = 16'h00FF;
        tick();
        checks++;
        if ({busy, owner} !== 2'b10 || mem_addr !== 16'h0010) begin
            errors++; $display("FAIL cont_first: got busy=%b own=%b addr=%h expected 1 0 0010", busy, owner, mem_addr);
        end
        tick(); tick();
        checks++;
        if ({r0_ack, r1_ack} !== 2'b10 || r0_rdata !== 16'hBEEF) begin
            errors++; $display("FAIL cont_ack0: got r0_ack=%b r1_ack=%b rdata=%h expected 1 0 beef", r0_ack, r1_ack, r0_rdata);
        end
        r0_req = 0;
        tick();
        checks++;
        if ({busy, dbg_state} !== {1'b0, S_IDLE}) begin
            errors++; $display("FAIL cont_gap: got busy=%b st=%0d expected 0 0", busy, dbg_state);
        end
        tick();
        checks++;
        if ({busy, owner, dbg_state} !== {2'b11, S_ISSUE} || mem_addr !== 16'h00FF) begin
            errors++; $display("FAIL cont_second: got busy=%b own=%b st=%0d addr=%h expected 1 1 1 00ff", busy, owner, dbg_state, mem_addr);
        end
        tick(); tick();
        checks++;
        if ({r0_ack, r1_ack} !== 2'b01 || r1_rdata !== 16'h1234) begin
            errors++; $display("FAIL cont_ack1: got r0_ack=%b r1_ack=%b rdata=%h expected 0 1 1234", r0_ack, r1_ack, r1_rdata);
        end
        r1_req = 0;
        tick();
    endtask

    task automatic test_back_to_back();
        r0_req = 1; r0_we = 1; r0_addr = 16'h0100; r0_wdata = 16'hA000;
        r1_req = 1; r1_we = 1; r1_addr = 16'h0200; r1_wdata = 16'hB000;
        for (int t = 0; t < 6; t++) begin
            logic exp_own;
            exp_own = t[0];
            tick();
            checks++;
            if ({busy, owner, mem_wren} !== {1'b1, exp_own, 1'b1}) begin
                errors++; $display("FAIL b2b_issue[%0d]: got busy=%b own=%b wren=%b expected 1 %b 1", t, busy, owner, mem_wren, exp_own);
            end
            tick();
            checks++;
            if ({r0_ack, r1_ack} !== {~exp_own, exp_own}) begin
                errors++; $display("FAIL b2b_ack[%0d]: got r0_ack=%b r1_ack=%b expected %b %b", t, r0_ack, r1_ack, ~exp_own, exp_own);
            end
            if (t == 5) begin
                r0_req = 0; r1_req = 0;
            end
            tick();
            checks++;
            if ({busy, dbg_state} !== {1'b0, S_IDLE}) begin
                errors++; $display("FAIL b2b_idle[%0d]: got busy=%b st=%0d expected 0 0", t, busy, dbg_state);
            end
        end
        tick();
        checks++;
        if (busy !== 1'b0 || mem_a[16'h0100] !== 16'hA000 || mem_a[16'h0200] !== 16'hB000) begin
            errors++; $display("FAIL b2b_end: got busy=%b m100=%h m200=%h expected 0 a000 b000", busy, mem_a[16'h0100], mem_a[16'h0200]);
        end
        r0_we = 0; r1_we = 0;
    endtask

    task automatic test_reset_mid();
        r0_req = 1; r0_we = 0; r0_addr = 16'h0010;
        tick(); tick();
        checks++;
        if (dbg_state !== S_WAIT) begin
            errors++; $display("FAIL mid_in_wait: got st=%0d expected 2", dbg_state);
        end
        reset = 0;
        tick();
        checks++;
        if ({r0_ack, r1_ack, busy, owner, mem_wren, dbg_state} !== 7'b0 || {mem_addr, mem_wdata, r0_rdata, r1_rdata} !== 64'h0) begin
            errors++; $display("FAIL mid_reset: got flags=%b st=%0d data=%h expected all 0",
                               {r0_ack, r1_ack, busy, owner, mem_wren}, dbg_state, {mem_addr, mem_wdata, r0_rdata, r1_rdata});
        end
        reset = 1;
        tick();
        checks++;
        if ({r0_ack, dbg_state} !== {1'b0, S_ISSUE}) begin
            errors++; $display("FAIL mid_restart: got ack=%b st=%0d expected 0 1", r0_ack, dbg_state);
        end
        tick(); tick();
        checks++;
        if (r0_ack !== 1'b1 || r0_rdata !== 16'hBEEF) begin
            errors++; $display("FAIL mid_complete: got ack=%b rdata=%h expected 1 beef", r0_ack, r0_rdata);
        end
        r0_req = 0;
        tick();
    endtask

    task automatic test_rd_lat1();
        b_r0_req = 1; b_r0_we = 0; b_r0_addr = 16'h0020;
        tick();
        checks++;
        if ({b_dbg_state, b_r0_ack} !== {S_ISSUE, 1'b0} || b_mem_addr !== 16'h0020) begin
            errors++; $display("FAIL lat1_issue: got st=%0d ack=%b addr=%h expected 1 0 0020", b_dbg_state, b_r0_ack, b_mem_addr);
        end
        tick();
        checks++;
        if ({b_dbg_state, b_r0_ack, b_r1_ack} !== {S_ACK, 2'b10} || b_r0_rdata !== 16'hCAFE) begin
            errors++; $display("FAIL lat1_ack: got st=%0d r0_ack=%b r1_ack=%b rdata=%h expected 3 1 0 cafe",
                               b_dbg_state, b_r0_ack, b_r1_ack, b_r0_rdata);
        end
        b_r0_req = 0;
        tick();
        checks++;
        if ({b_busy, b_r0_ack, b_dbg_state} !== {2'b00, S_IDLE}) begin
            errors++; $display("FAIL lat1_after: got busy=%b ack=%b st=%0d expected 0 0 0", b_busy, b_r0_ack, b_dbg_state);
        end
    endtask

    initial begin
        test_reset();
        test_read_r0();
        test_write_r1();
        test_contention();
        test_back_to_back();
        test_reset_mid();
        test_rd_lat1();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        errors++;
        $display("FAIL timeout: simulation did not finish within 100000 time units");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "timeout");
    end

endmodule
